lsu_mem_if: RTL
===============

Name: lsu_mem_if

Overview:
- Load/store initiator between the execute stage and the byte-enabled data memory.
- Accepts one load or store request at a time. Issues only word-aligned memory accesses, splitting any access that crosses a word boundary into two beats.
- Assembles the load result with sign or zero extension and returns it through a single-cycle response strobe.

Parameters:
- ADDR_MAX, 4095: highest valid byte address of the data memory. Any accessed byte above it is an error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- resp_valid_o  out  1  one-cycle completion strobe
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  illegal funct3 or out-of-range access; valid with resp_valid_o
- mem_addr_o  out  32  word-aligned address, bits [1:0] always 00
- mem_wr_en_o  out  1  memory write enable
- mem_wr_data_o  out  32  lane-positioned write data
- mem_byte_en_o  out  4  lane enables; bit k = byte at mem_addr_o+k = data bits [8k+7:8k]
- mem_rd_data_i  in  32  combinational read data, same lane mapping

Behaviour:
- Handshake:
  - req_ready_o = 1 only in IDLE.
  - A request is accepted on a rising edge where req_valid_i && req_ready_o. All request fields are registered at that edge.
- States: IDLE, BEAT0, BEAT1, RESP. Reset forces IDLE.
- Size and offset:
  - size = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
  - Split access when off + size > 4.
- Error check, at acceptance:
  - Error if funct3 is 011, 110 or 111, if a store has funct3[2] = 1, or if addr + size - 1 > ADDR_MAX.
  - On error: IDLE -> RESP directly, no memory access, resp_err_o = 1.
- BEAT0:
  - mem_addr_o = {addr[31:2], 2'b00}.
  - mem_byte_en_o = size mask shifted left by off, truncated to 4 bits.
  - Stores: mem_wr_data_o = wdata shifted left by 8*off; mem_wr_en_o = 1.
  - Loads: the enabled lanes of mem_rd_data_i are captured into a 64-bit assembly register at byte positions off..3.
  - Next state is BEAT1 if split, else RESP.
- BEAT1:
  - mem_addr_o = BEAT0 address + 4.
  - mem_byte_en_o = the remaining low lanes.
  - Store data = the remaining high bytes of wdata placed from lane 0.
  - Loads capture lanes into byte positions 4..7. Next state RESP.
- RESP:
  - resp_valid_o = 1 for exactly one cycle, then IDLE.
  - resp_rdata_o = assembly bytes off..off+size-1, sign-extended for LB/LH and zero-extended otherwise.
- Latency, from the accept edge to the cycle with resp_valid_o high:
  - aligned access: 2 cycles
  - split access: 3 cycles
  - error: 1 cycle
- Outside BEAT0/BEAT1, mem_wr_en_o = 0, mem_byte_en_o = 0, mem_addr_o = 0, mem_wr_data_o = 0. Memory outputs decode combinationally from registered state.
- Reset values: req_ready_o = 1; all other outputs 0.
- Reset mid-operation:
  - Returns to IDLE and no response is produced.
  - A split store reset after BEAT0 leaves its first beat committed. This is permitted and documented.
- req_valid_i outside IDLE is ignored; the requester must hold it until ready.

Decomposition:
- Package lsu_pkg holds:
  - funct3 width localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum lsu_state_t
  - a size_from_funct3 function
- One sub-module, lsu_load_align: combinational byte select and sign/zero extension from the assembly register, off and funct3. It is reused by later cache work.

Test Plan:
- Aligned SW addr 0x100 data 0xDEADBEEF -> one BEAT0 with mem_addr_o=0x100, byte_en=1111, wr_data=0xDEADBEEF; resp_valid 2 cycles after accept; a following LW 0x100 returns 0xDEADBEEF.
- SB addr 0x103 data 0x000000A5, then LB 0x103 -> store byte_en=1000, wr_data=0xA5000000; load resp_rdata=0xFFFFFFA5; LBU 0x103 returns 0x000000A5.
- Split SW addr 0x0FE data 0x11223344 -> BEAT0 addr 0x0FC en 1100 data 0x33440000; BEAT1 addr 0x100 en 0011 data 0x00001122; LW 0x0FE returns 0x11223344 after 3 cycles.
- LH addr 0x0FF over stored bytes 0x80 at 0x0FF and 0x7F at 0x100 -> split load, resp_rdata=0x00007F80. With byte 0x100 = 0x80 instead, the result is 0xFFFF8080.
- Errors: LW addr 0xFFE (ADDR_MAX=4095), and a request with funct3=011 -> no mem_wr_en or byte_en activity; resp_err_o=1 and resp_rdata_o=0 one cycle after accept.
- Reset asserted during BEAT1 of a split store -> next cycle IDLE, req_ready_o=1, no resp_valid_o; back-to-back requests with req_valid_i held high are each accepted only in IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM states and size decode for the load/store unit
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   // Illegal codes fall through to 4; they are rejected before any beat is issued.
   function automatic logic [2:0] size_from_funct3(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: return 3'd1;
         F3_H, F3_HU: return 3'd2;
         default:     return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects load bytes from the assembly register and sign/zero extends them
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [63:0] asm_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] win;

   always_comb begin
      win = 32'(asm_i >> {off_i, 3'b000});
      case (funct3_i)
         F3_B:    data_o = {{24{win[7]}}, win[7:0]};
         F3_H:    data_o = {{16{win[15]}}, win[15:0]};
         F3_W:    data_o = win;
         F3_BU:   data_o = {24'd0, win[7:0]};
         F3_HU:   data_o = {16'd0, win[15:0]};
         default: data_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - single-outstanding load/store initiator issuing word-aligned, possibly split, beats
module lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_MAX = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_wr_data_o,
   output logic [3:0]  mem_byte_en_o,
   input  logic [31:0] mem_rd_data_i
);

   lsu_state_t  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [63:0] asm_q, asm_d;

   logic [2:0]  req_size;
   logic [32:0] req_last;
   logic        req_err;
   logic [2:0]  size;
   logic [1:0]  off;
   logic [3:0]  size_mask;
   logic [31:0] wdata_mask;
   logic [7:0]  en_pos;
   logic [63:0] wdata_pos;
   logic        split;
   logic [31:0] word_addr;
   logic [31:0] align_data;

   always_comb begin
      req_size = size_from_funct3(req_funct3_i);
      req_last = {1'b0, req_addr_i} + 33'(req_size) - 33'd1;
      req_err  = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                 (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]) ||
                 (req_last > 33'(ADDR_MAX));
   end

   // Beat lanes and data come from a 64-bit window: low half is BEAT0, high half BEAT1.
   always_comb begin
      size = size_from_funct3(funct3_q);
      off  = addr_q[1:0];
      case (size)
         3'd1:    begin size_mask = 4'b0001; wdata_mask = 32'h0000_00FF; end
         3'd2:    begin size_mask = 4'b0011; wdata_mask = 32'h0000_FFFF; end
         default: begin size_mask = 4'b1111; wdata_mask = 32'hFFFF_FFFF; end
      endcase
      en_pos    = {4'b0000, size_mask} << off;
      wdata_pos = {32'd0, wdata_q & wdata_mask} << {off, 3'b000};
      split     = |en_pos[7:4];
      word_addr = {addr_q[31:2], 2'b00};
   end

   always_comb begin
      mem_addr_o    = 32'd0;
      mem_wr_en_o   = 1'b0;
      mem_wr_data_o = 32'd0;
      mem_byte_en_o = 4'b0000;
      if (state_q == ST_BEAT0) begin
         mem_addr_o    = word_addr;
         mem_byte_en_o = en_pos[3:0];
         mem_wr_en_o   = we_q;
         mem_wr_data_o = we_q ? wdata_pos[31:0] : 32'd0;
      end else if (state_q == ST_BEAT1) begin
         mem_addr_o    = word_addr + 32'd4;
         mem_byte_en_o = en_pos[7:4];
         mem_wr_en_o   = we_q;
         mem_wr_data_o = we_q ? wdata_pos[63:32] : 32'd0;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      asm_d    = asm_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_d     = req_we_i;
               funct3_d = req_funct3_i;
               addr_d   = req_addr_i;
               wdata_d  = req_wdata_i;
               err_d    = req_err;
               asm_d    = 64'd0;
               state_d  = req_err ? ST_RESP : ST_BEAT0;
            end
         end
         ST_BEAT0: begin
            for (int k = 0; k < 4; k++) begin
               if (!we_q && en_pos[k]) asm_d[8*k +: 8] = mem_rd_data_i[8*k +: 8];
            end
            state_d = split ? ST_BEAT1 : ST_RESP;
         end
         ST_BEAT1: begin
            for (int k = 0; k < 4; k++) begin
               if (!we_q && en_pos[4+k]) asm_d[8*(k+4) +: 8] = mem_rd_data_i[8*k +: 8];
            end
            state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         err_q    <= 1'b0;
         asm_q    <= 64'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         asm_q    <= asm_d;
      end
   end

   lsu_load_align u_load_align (
      .asm_i    (asm_q),
      .off_i    (off),
      .funct3_i (funct3_q),
      .data_o   (align_data)
   );

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = (state_q == ST_RESP);
   assign resp_err_o   = (state_q == ST_RESP) && err_q;
   assign resp_rdata_o = ((state_q == ST_RESP) && !err_q && !we_q) ? align_data : 32'd0;

endmodule
